// File: rtl/tlul_pkg.sv
// Minimal TL-UL type set shared by the peripheral crossbar and its devices.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/xbar_peri_pkg.sv
// Address map and device indices for the peripheral crossbar.
package xbar_peri_pkg;

  localparam int NDEV_DEFAULT = 4;

  localparam logic [NDEV_DEFAULT-1:0][31:0] DEV_BASE = {
    32'h4003_0000, 32'h4002_0000, 32'h4001_0000, 32'h4000_0000
  };

  localparam logic [NDEV_DEFAULT-1:0][31:0] DEV_MASK = {NDEV_DEFAULT{32'h0000_0FFF}};

  typedef enum logic [4:0] {
    DevIdx0   = 5'd0,
    DevIdx1   = 5'd1,
    DevIdx2   = 5'd2,
    DevIdx3   = 5'd3,
    DevIdxErr = 5'd4
  } dev_idx_e;

endpackage

// File: rtl/tlul_err_resp.sv
// Single-entry TL-UL error responder for accesses that decode to no device.
module tlul_err_resp
  import tlul_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_h2d_i,
  output tl_d2h_t tl_d2h_o
);

  logic       pend_q, pend_d;
  logic       accept;
  logic [7:0] src_q;
  logic [1:0] size_q;
  tl_a_op_e   op_q;
  logic       unused_h2d;

  assign accept     = tl_h2d_i.a_valid & ~pend_q;
  assign unused_h2d = ^{tl_h2d_i.a_param, tl_h2d_i.a_address, tl_h2d_i.a_mask, tl_h2d_i.a_data};

  always_comb begin
    pend_d = pend_q;
    if (accept) begin
      pend_d = 1'b1;
    end else if (pend_q && tl_h2d_i.d_ready) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Captured request fields are only meaningful while pend_q is set.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      src_q  <= tl_h2d_i.a_source;
      size_q <= tl_h2d_i.a_size;
      op_q   <= tl_h2d_i.a_opcode;
    end
  end

  always_comb begin
    tl_d2h_o          = '0;
    tl_d2h_o.a_ready  = ~pend_q;
    tl_d2h_o.d_valid  = pend_q;
    tl_d2h_o.d_opcode = (op_q == Get) ? AccessAckData : AccessAck;
    tl_d2h_o.d_size   = size_q;
    tl_d2h_o.d_source = src_q;
    tl_d2h_o.d_data   = 32'hFFFF_FFFF;
    tl_d2h_o.d_error  = 1'b1;
  end

endmodule

// File: rtl/tlul_xbar_peri_n.sv
// 1-to-N TL-UL peripheral crossbar: address decode, in-order steering, error target.
module tlul_xbar_peri_n
  import tlul_pkg::*;
  import xbar_peri_pkg::*;
#(
  parameter int                         NDev           = NDEV_DEFAULT,
  parameter int                         MaxOutstanding = 4,
  parameter logic [NDev-1:0][31:0]      DevBase        = DEV_BASE,
  parameter logic [NDev-1:0][31:0]      DevMask        = DEV_MASK
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_h2d_main,
  output tl_d2h_t tl_d2h_main,
  output tl_h2d_t tl_h2d_dev [NDev],
  input  tl_d2h_t tl_d2h_dev [NDev]
);

  localparam int SteerW = $clog2(NDev + 1);
  localparam int CntW   = $clog2(MaxOutstanding + 1);

  logic [SteerW-1:0] steer_q, steer_d, dec;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              stall, a_acc, d_acc;
  tl_d2h_t           tgt_d2h [NDev+1];
  tl_h2d_t           err_h2d;
  tl_d2h_t           err_d2h;

  // Lowest matching index wins, so scan from the top down.
  always_comb begin
    dec = SteerW'(NDev);
    for (int i = NDev - 1; i >= 0; i--) begin
      if ((tl_h2d_main.a_address & ~DevMask[i]) == DevBase[i]) begin
        dec = SteerW'(i);
      end
    end
  end

  // Responses come back in order only if every outstanding request went to one target.
  assign stall = ((cnt_q != '0) && (dec != steer_q)) ||
                 (cnt_q == CntW'(MaxOutstanding));

  always_comb begin
    for (int i = 0; i < NDev; i++) begin
      tgt_d2h[i] = tl_d2h_dev[i];
    end
    tgt_d2h[NDev] = err_d2h;
  end

  always_comb begin
    for (int i = 0; i < NDev; i++) begin
      tl_h2d_dev[i]         = tl_h2d_main;
      tl_h2d_dev[i].a_valid = tl_h2d_main.a_valid & ~stall & ~rst_i & (dec == SteerW'(i));
      tl_h2d_dev[i].d_ready = tl_h2d_main.d_ready & (steer_q == SteerW'(i));
    end
    err_h2d         = tl_h2d_main;
    err_h2d.a_valid = tl_h2d_main.a_valid & ~stall & ~rst_i & (dec == SteerW'(NDev));
    err_h2d.d_ready = tl_h2d_main.d_ready & (steer_q == SteerW'(NDev));
  end

  always_comb begin
    tl_d2h_main         = tgt_d2h[steer_q];
    tl_d2h_main.d_valid = tgt_d2h[steer_q].d_valid & ~rst_i;
    tl_d2h_main.a_ready = tgt_d2h[dec].a_ready & ~stall & ~rst_i;
  end

  assign a_acc = tl_h2d_main.a_valid & tl_d2h_main.a_ready;
  assign d_acc = tl_d2h_main.d_valid & tl_h2d_main.d_ready;

  always_comb begin
    steer_d = steer_q;
    cnt_d   = cnt_q;
    if (a_acc) begin
      steer_d = dec;
    end
    if (a_acc && !d_acc && (cnt_q != CntW'(MaxOutstanding))) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (d_acc && !a_acc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      steer_q <= '0;
      cnt_q   <= '0;
    end else begin
      steer_q <= steer_d;
      cnt_q   <= cnt_d;
    end
  end

  tlul_err_resp u_err_resp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .tl_h2d_i (err_h2d),
    .tl_d2h_o (err_d2h)
  );

endmodule

// File: tb/tb_tlul_xbar_peri_n.sv
// Directed bench for tlul_xbar_peri_n: decode table plus multi-cycle sequences.
module tb_tlul_xbar_peri_n;
  import tlul_pkg::*;
  import xbar_peri_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  tl_h2d_t h2d;
  tl_d2h_t d2h;
  tl_h2d_t dev_h2d [4];
  tl_d2h_t dev_d2h [4];

  int total  = 0;
  int passed = 0;

  tlul_xbar_peri_n #(.NDev(4), .MaxOutstanding(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tl_h2d_main (h2d),
    .tl_d2h_main (d2h),
    .tl_h2d_dev  (dev_h2d),
    .tl_d2h_dev  (dev_d2h)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rdy;
    logic [3:0]  exp_vld;
    logic        exp_ardy;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [3:0] dev_vld();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = dev_h2d[i].a_valid;
    return v;
  endfunction

  task automatic idle();
    h2d.a_valid = 1'b0;
    h2d.d_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dev_d2h[i].d_valid = 1'b0;
      dev_d2h[i].a_ready = 1'b1;
    end
  endtask

  initial begin
    vecs[0] = '{32'h4001_0010, 4'b1111, 4'b0010, 1'b1};
    vecs[1] = '{32'h4000_0000, 4'b1111, 4'b0001, 1'b1};
    vecs[2] = '{32'h4000_0FFF, 4'b1111, 4'b0001, 1'b1};
    vecs[3] = '{32'h4000_1000, 4'b1111, 4'b0000, 1'b1};
    vecs[4] = '{32'h4003_0ABC, 4'b0111, 4'b1000, 1'b0};
    vecs[5] = '{32'h4002_0004, 4'b1011, 4'b0100, 1'b0};
    vecs[6] = '{32'h5000_0000, 4'b0000, 4'b0000, 1'b1};
    vecs[7] = '{32'h3FFF_FFFF, 4'b1111, 4'b0000, 1'b1};

    rst = 1'b1;
    h2d = '0;
    h2d.a_mask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      dev_d2h[i] = '0;
      dev_d2h[i].d_data = 32'h1000 + i;
    end
    idle();

    // Outputs held quiet during reset even with live inputs.
    step();
    h2d.a_valid = 1'b1; h2d.a_address = 32'h4000_0000; h2d.a_opcode = Get;
    dev_d2h[0].d_valid = 1'b1; h2d.d_ready = 1'b1;
    #1;
    chk("rst_dev0_avalid", 32'(dev_h2d[0].a_valid), 0);
    chk("rst_host_aready", 32'(d2h.a_ready), 0);
    chk("rst_host_dvalid", 32'(d2h.d_valid), 0);
    chk("rst_cnt", 32'(dut.cnt_q), 0);
    chk("rst_steer", 32'(dut.steer_q), 0);
    idle();
    step();
    rst = 1'b0;
    step();

    // Decode table, a_valid only between edges so nothing is accepted.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 4; i++) dev_d2h[i].a_ready = vecs[v].rdy[i];
      h2d.a_address = vecs[v].addr;
      h2d.a_opcode  = Get;
      h2d.a_valid   = 1'b1;
      #1;
      chk($sformatf("dec_vld[%0d]", v), 32'(dev_vld()), 32'(vecs[v].exp_vld));
      chk($sformatf("dec_ardy[%0d]", v), 32'(d2h.a_ready), 32'(vecs[v].exp_ardy));
      h2d.a_valid = 1'b0;
      idle();
      step();
    end

    // Put to dev1, stray dev0 response ignored, dev1 response forwarded.
    h2d.a_valid = 1'b1; h2d.a_address = 32'h4001_0010; h2d.a_opcode = PutFullData;
    h2d.a_data = 32'h0000_CAFE;
    #1;
    chk("put1_vld", 32'(dev_vld()), 32'b0010);
    chk("put1_data", dev_h2d[1].a_data, 32'h0000_CAFE);
    step();
    h2d.a_valid = 1'b0;
    chk("put1_cnt1", 32'(dut.cnt_q), 1);
    chk("put1_steer", 32'(dut.steer_q), 1);
    dev_d2h[0].d_valid = 1'b1; h2d.d_ready = 1'b1;
    #1;
    chk("stray_dvalid", 32'(d2h.d_valid), 0);
    chk("stray_dready", 32'(dev_h2d[0].d_ready), 0);
    step();
    chk("stray_cnt", 32'(dut.cnt_q), 1);
    dev_d2h[0].d_valid = 1'b0;
    dev_d2h[1].d_valid = 1'b1; dev_d2h[1].d_source = 8'd5;
    #1;
    chk("put1_dvalid", 32'(d2h.d_valid), 1);
    chk("put1_dsrc", 32'(d2h.d_source), 5);
    chk("put1_ddata", d2h.d_data, 32'h1001);
    chk("put1_dready1", 32'(dev_h2d[1].d_ready), 1);
    step();
    dev_d2h[1].d_valid = 1'b0;
    chk("put1_cnt0", 32'(dut.cnt_q), 0);
    idle();

    // Four Gets fill the outstanding budget; the fifth stalls.
    h2d.a_valid = 1'b1; h2d.a_address = 32'h4000_0000; h2d.a_opcode = Get;
    for (int k = 0; k < 4; k++) step();
    chk("full_cnt", 32'(dut.cnt_q), 4);
    chk("full_aready", 32'(d2h.a_ready), 0);
    chk("full_dev0_vld", 32'(dev_h2d[0].a_valid), 0);
    step();
    chk("full_hold_cnt", 32'(dut.cnt_q), 4);
    dev_d2h[0].d_valid = 1'b1; h2d.d_ready = 1'b1;
    #1;
    chk("full_aready_dacc", 32'(d2h.a_ready), 0);
    step();
    dev_d2h[0].d_valid = 1'b0;
    chk("full_cnt3", 32'(dut.cnt_q), 3);
    #1;
    chk("full_aready_free", 32'(d2h.a_ready), 1);
    step();
    h2d.a_valid = 1'b0;
    chk("refill_cnt4", 32'(dut.cnt_q), 4);

    // Simultaneous A and D accept at count 2.
    dev_d2h[0].d_valid = 1'b1;
    step(); step();
    chk("drain_cnt2", 32'(dut.cnt_q), 2);
    h2d.a_valid = 1'b1;
    #1;
    chk("both_aready", 32'(d2h.a_ready), 1);
    chk("both_dvalid", 32'(d2h.d_valid), 1);
    step();
    h2d.a_valid = 1'b0;
    chk("both_cnt2", 32'(dut.cnt_q), 2);
    step(); step();
    dev_d2h[0].d_valid = 1'b0;
    chk("drain_cnt0", 32'(dut.cnt_q), 0);
    step();
    chk("drain_floor", 32'(dut.cnt_q), 0);
    idle();

    // Target switch waits for the previous target to drain.
    h2d.a_valid = 1'b1; h2d.a_address = 32'h4000_0000; h2d.a_opcode = Get;
    step();
    h2d.a_address = 32'h4002_0000;
    #1;
    chk("sw_stall_ardy", 32'(d2h.a_ready), 0);
    chk("sw_stall_vld2", 32'(dev_h2d[2].a_valid), 0);
    dev_d2h[0].d_valid = 1'b1; h2d.d_ready = 1'b1;
    step();
    dev_d2h[0].d_valid = 1'b0;
    chk("sw_cnt0", 32'(dut.cnt_q), 0);
    #1;
    chk("sw_ardy", 32'(d2h.a_ready), 1);
    chk("sw_vld2", 32'(dev_h2d[2].a_valid), 1);
    step();
    h2d.a_valid = 1'b0;
    chk("sw_steer2", 32'(dut.steer_q), 32'(DevIdx2));
    chk("sw_cnt1", 32'(dut.cnt_q), 1);
    dev_d2h[2].d_valid = 1'b1;
    step();
    dev_d2h[2].d_valid = 1'b0;
    chk("sw_done_cnt", 32'(dut.cnt_q), 0);
    idle();

    // Unmapped Get answered by the error responder, held under backpressure.
    h2d.a_valid = 1'b1; h2d.a_address = 32'h5000_0000; h2d.a_opcode = Get;
    h2d.a_source = 8'd3; h2d.a_size = 2'd2;
    #1;
    chk("err_aready", 32'(d2h.a_ready), 1);
    step();
    h2d.a_valid = 1'b0;
    #1;
    chk("err_dvalid", 32'(d2h.d_valid), 1);
    chk("err_derror", 32'(d2h.d_error), 1);
    chk("err_dop", 32'(d2h.d_opcode), 32'(AccessAckData));
    chk("err_dsrc", 32'(d2h.d_source), 3);
    chk("err_dsize", 32'(d2h.d_size), 2);
    chk("err_ddata", d2h.d_data, 32'hFFFF_FFFF);
    chk("err_steer", 32'(dut.steer_q), 32'(DevIdxErr));
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("err_hold_vld[%0d]", k), 32'(d2h.d_valid), 1);
      chk($sformatf("err_hold_src[%0d]", k), 32'(d2h.d_source), 3);
    end
    h2d.a_valid = 1'b1; h2d.a_address = 32'h6000_0000; h2d.a_opcode = PutFullData;
    #1;
    chk("err_busy_aready", 32'(d2h.a_ready), 0);
    h2d.a_valid = 1'b0;
    h2d.d_ready = 1'b1;
    step();
    h2d.d_ready = 1'b0;
    chk("err_clr_dvalid", 32'(d2h.d_valid), 0);
    chk("err_clr_cnt", 32'(dut.cnt_q), 0);
    h2d.a_valid = 1'b1; h2d.a_source = 8'd7;
    step();
    h2d.a_valid = 1'b0;
    #1;
    chk("err_put_dop", 32'(d2h.d_opcode), 32'(AccessAck));
    chk("err_put_dsrc", 32'(d2h.d_source), 7);
    h2d.d_ready = 1'b1;
    step();
    idle();

    // Reset mid-transaction discards three outstanding requests.
    h2d.a_valid = 1'b1; h2d.a_address = 32'h4000_0000; h2d.a_opcode = Get;
    step(); step(); step();
    chk("mid_cnt3", 32'(dut.cnt_q), 3);
    dev_d2h[0].d_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_cnt", 32'(dut.cnt_q), 0);
    chk("mid_rst_vld0", 32'(dev_h2d[0].a_valid), 0);
    chk("mid_rst_dvalid", 32'(d2h.d_valid), 0);
    chk("mid_rst_aready", 32'(d2h.a_ready), 0);
    step();
    rst = 1'b0;
    idle();
    #1;
    chk("post_rst_cnt", 32'(dut.cnt_q), 0);
    h2d.a_valid = 1'b1; h2d.a_address = 32'h4003_0000; h2d.a_opcode = PutFullData;
    #1;
    chk("post_put_vld", 32'(dev_vld()), 32'b1000);
    chk("post_put_ardy", 32'(d2h.a_ready), 1);
    step();
    h2d.a_valid = 1'b0;
    chk("post_put_cnt1", 32'(dut.cnt_q), 1);
    chk("post_put_steer", 32'(dut.steer_q), 32'(DevIdx3));
    dev_d2h[3].d_valid = 1'b1; h2d.d_ready = 1'b1;
    #1;
    chk("post_put_dvalid", 32'(d2h.d_valid), 1);
    chk("post_put_ddata", d2h.d_data, 32'h1003);
    step();
    chk("post_put_cnt0", 32'(dut.cnt_q), 0);
    idle();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tlul_xbar_peri_n.md
TLUL_XBAR_PERI_N -- requirements
Module: tlul_xbar_peri_n

Interface
REQ-001 SHALL have parameter NDev, default 4, number of peripheral device ports (1..16).
REQ-002 SHALL have parameter MaxOutstanding, default 4, maximum accepted-but-unanswered requests (1..15).
REQ-003 SHALL have parameter DevBase, default {0x4003_0000,0x4002_0000,0x4001_0000,0x4000_0000}, NDev x 32-bit base addresses.
REQ-004 SHALL have parameter DevMask, default 0x0000_0FFF for every device, NDev x 32-bit offset masks.
REQ-005 SHALL have port clk_i  input  1  single clock; all state on its rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port tl_h2d_main  input  tlul_pkg::tl_h2d_t  request from xbar_main (host).
REQ-008 SHALL have port tl_d2h_main  output  tlul_pkg::tl_d2h_t  response to xbar_main.
REQ-009 SHALL have port tl_h2d_dev  output  NDev x tlul_pkg::tl_h2d_t  requests to peripherals.
REQ-010 SHALL have port tl_d2h_dev  input  NDev x tlul_pkg::tl_d2h_t  responses from peripherals.

Function
REQ-011 Decode SHALL select the lowest index i with (a_address & ~DevMask[i]) == DevBase[i]; no match selects the internal error target (index NDev).
REQ-012 Stall SHALL be asserted when count != 0 and the decoded target != steer register, or when count == MaxOutstanding.
REQ-013 A-channel SHALL pass combinationally (zero latency): selected target gets a_valid = host a_valid & ~stall with all other A fields unchanged; all non-selected devices get a_valid = 0.
REQ-014 Host a_ready SHALL equal the selected target's a_ready & ~stall.
REQ-015 A-accept (host a_valid & a_ready) SHALL load the steer register with the decoded target index.
REQ-016 Outstanding count SHALL increment on A-accept and decrement on D-accept (host d_valid & d_ready); when both occur in one cycle, count SHALL be unchanged.
REQ-017 All host D fields and d_valid SHALL come from the target named by the steer register; d_ready SHALL go only to that target, 0 to all others.
REQ-018 d_valid from a non-steered device SHALL be ignored and SHALL NOT change count.
REQ-019 Error responder SHALL hold one entry: a_ready = ~pending; on accept it captures a_source, a_size and a_opcode.
REQ-020 Error responder SHALL assert d_valid the cycle after accept (latency 1), with d_error = 1, d_data = 0xFFFF_FFFF, d_opcode = AccessAckData for Get, AccessAck otherwise, and captured d_source/d_size.
REQ-021 Error responder d_valid SHALL hold with stable fields until d_ready; pending clears on that cycle.
REQ-022 count SHALL never exceed MaxOutstanding nor wrap below 0; a D-accept with count == 0 is a protocol error and SHALL leave count at 0.

Reset
REQ-023 While rst_i is high: count = 0, steer = 0, error responder empty.
REQ-024 While rst_i is high: every device a_valid = 0, host d_valid = 0, host a_ready = 0.
REQ-025 Reset assertion mid-transaction SHALL discard all outstanding state; the first cycle after deassertion SHALL behave as idle.

Structure
REQ-026 The shared package xbar_peri_pkg SHALL hold the NDev default, the address-map constants (DevBase/DevMask) and the device index enumeration; TL-UL types and opcodes come from tlul_pkg.
REQ-027 The error responder SHALL be a sub-module, tlul_err_resp, with one tl_h2d_t input and one tl_d2h_t output.

Verification
REQ-028 Put to 0x4001_0010, device 1 acks next cycle -> only dev1 sees a_valid; host gets dev1 response; count goes 0 -> 1 -> 0.
REQ-029 Four back-to-back Gets to 0x4000_0000 with MaxOutstanding=4 and device 0 withholding D -> 5th Get stalls (a_ready=0) until one D-accept.
REQ-030 Get to 0x4002_0000 while a dev0 request is outstanding -> stalled; accepted the cycle after count reaches 0; steer becomes 2.
REQ-031 Get to unmapped 0x5000_0000 with source 3 -> one cycle later d_valid, d_error=1, AccessAckData, d_source=3, d_data=0xFFFF_FFFF; held under d_ready=0 for 3 cycles.
REQ-032 Simultaneous A-accept and D-accept at count=2 -> count remains 2.
REQ-033 rst_i pulsed with count=3 -> all valids 0, count 0; next Put to 0x4003_0000 completes normally.
